// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the DRAM-side system bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned SYSBUS_DATA_W    = 64;
  localparam int unsigned SYSBUS_TAG_W     = 13;
  localparam int unsigned SYSBUS_BEATS     = 8;
  localparam int unsigned SYSBUS_WRITE_BIT = 12;
  localparam logic        SYSBUS_WRITE     = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WDATA,
    RDATA
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-input round-robin pick: on a tie the master that did not win last time gets the grant.
module rr_arbiter2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic grant_o
);

  assign valid_o = req0_i | req1_i;
  assign grant_o = (req0_i & req1_i) ? ~last_grant_i : req1_i;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave system bus arbiter; the owner keeps the bus for request plus all data beats.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = SYSBUS_DATA_W,
  parameter int unsigned BUS_TAG_WIDTH  = SYSBUS_TAG_W,
  parameter int unsigned BEATS          = SYSBUS_BEATS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_reqcyc,
  output logic                      m0_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] m0_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
  output logic                      m0_respcyc,
  input  logic                      m0_respack,
  output logic [BUS_DATA_WIDTH-1:0] m0_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
  input  logic                      m1_reqcyc,
  output logic                      m1_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] m1_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
  output logic                      m1_respcyc,
  input  logic                      m1_respack,
  output logic [BUS_DATA_WIDTH-1:0] m1_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
  output logic                      s_reqcyc,
  input  logic                      s_reqack,
  output logic [BUS_DATA_WIDTH-1:0] s_req,
  output logic [BUS_TAG_WIDTH-1:0]  s_reqtag,
  input  logic                      s_respcyc,
  output logic                      s_respack,
  input  logic [BUS_DATA_WIDTH-1:0] s_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  s_resptag,
  output logic                      busy,
  output logic                      owner
);

  localparam int unsigned CNT_W = $clog2(BEATS) + 1;

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic             is_write_q, is_write_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic arb_valid, arb_grant;

  // Owner-side view of the two masters.
  logic                      own_reqcyc, own_respack;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
  logic                      own_reqack, own_respcyc;
  logic [BUS_DATA_WIDTH-1:0] own_resp;
  logic [BUS_TAG_WIDTH-1:0]  own_resptag;

  rr_arbiter2 u_rr (
    .req0_i       (m0_reqcyc),
    .req1_i       (m1_reqcyc),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid),
    .grant_o      (arb_grant)
  );

  assign own_reqcyc  = owner_q ? m1_reqcyc  : m0_reqcyc;
  assign own_req     = owner_q ? m1_req     : m0_req;
  assign own_reqtag  = owner_q ? m1_reqtag  : m0_reqtag;
  assign own_respack = owner_q ? m1_respack : m0_respack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      is_write_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      is_write_q   <= is_write_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    is_write_d   = is_write_q;
    cnt_d        = cnt_q;
    s_reqcyc     = 1'b0;
    s_req        = '0;
    s_reqtag     = '0;
    s_respack    = 1'b0;
    own_reqack   = 1'b0;
    own_respcyc  = 1'b0;
    own_resp     = '0;
    own_resptag  = '0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d      = arb_grant;
          last_grant_d = arb_grant;
          is_write_d   = (arb_grant ? m1_reqtag[SYSBUS_WRITE_BIT]
                                    : m0_reqtag[SYSBUS_WRITE_BIT]) == SYSBUS_WRITE;
          state_d      = REQ;
        end
      end
      REQ: begin
        s_reqcyc   = own_reqcyc;
        s_req      = own_req;
        s_reqtag   = own_reqtag;
        own_reqack = s_reqack;
        if (s_reqack) begin
          state_d = is_write_q ? WDATA : RDATA;
          cnt_d   = '0;
        end
      end
      WDATA: begin
        s_reqcyc   = own_reqcyc;
        s_req      = own_req;
        s_reqtag   = own_reqtag;
        own_reqack = s_reqack;
        if (own_reqcyc && s_reqack) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = IDLE;
        end
      end
      RDATA: begin
        own_respcyc = s_respcyc;
        own_resp    = s_resp;
        own_resptag = s_resptag;
        s_respack   = own_respack;
        if (s_respcyc && own_respack) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Non-owner always sees an idle bus.
  assign m0_reqack  = ~owner_q & own_reqack;
  assign m0_respcyc = ~owner_q & own_respcyc;
  assign m0_resp    = owner_q ? '0 : own_resp;
  assign m0_resptag = owner_q ? '0 : own_resptag;
  assign m1_reqack  = owner_q & own_reqack;
  assign m1_respcyc = owner_q & own_respcyc;
  assign m1_resp    = owner_q ? own_resp : '0;
  assign m1_resptag = owner_q ? own_resptag : '0;

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule
